// File: rtl/adc_pkt_gen_if.sv
// adc_pkt_gen_if
//   Bundles the self-test generator's register inputs, its start pulse and
//   its frame output bus.
//   master : the generator (adc_pkt_gen) - consumes the register fields and
//            start, drives pkt_gen_data/pkt_gen_vld/busy/done.
//   slave  : the register block / downstream consumer side.
interface adc_pkt_gen_if #(
    parameter int LANES = 96,
    parameter int DW    = 9
);
    logic                  rf_self_mode;
    logic [1:0]            rf_pat_mode;
    logic [DW-1:0]         rf_pat_seed;
    logic [15:0]           rf_burst_len;
    logic                  start;
    logic [DW*LANES-1:0]   pkt_gen_data;
    logic                  pkt_gen_vld;
    logic                  busy;
    logic                  done;

    modport master (
        input  rf_self_mode, rf_pat_mode, rf_pat_seed, rf_burst_len, start,
        output pkt_gen_data, pkt_gen_vld, busy, done
    );

    modport slave (
        output rf_self_mode, rf_pat_mode, rf_pat_seed, rf_burst_len, start,
        input  pkt_gen_data, pkt_gen_vld, busy, done
    );
endinterface

// File: rtl/adc_pkt_gen.sv
// adc_pkt_gen
//   Self-test pattern generator for the ADC capture path. After a start pulse
//   (with rf_self_mode set) it emits one LANES x DW frame per clock for
//   rf_burst_len frames (0 = continuous until rf_self_mode drops). Patterns:
//   0 ramp, 1 constant, 2 PRBS9 (x^9+x^5+1), 3 toggle.
//
//   Ports:
//     clk  - sole clock
//     rst  - asynchronous, active-high reset
//     bus  - adc_pkt_gen_if.master: register fields + start in,
//            pkt_gen_data / pkt_gen_vld / busy / done out (all registered)
//
//   Build option:
//     ADC_PKT_GEN_PRBS_EN - when defined, mode 2 produces PRBS9 through an
//     unrolled LFSR network; when undefined no LFSR is built and mode 2 is
//     a ramp.
module adc_pkt_gen #(
    parameter int LANES = 96,
    parameter int DW    = 9
) (
    input  logic              clk,
    input  logic              rst,
    adc_pkt_gen_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DW-1:0]       seed_q, seed_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         fcnt_q, fcnt_d;
    logic [DW-1:0]       base_q, base_d;   // ramp value of lane 0 in the current frame
    logic                odd_q, odd_d;     // toggle phase: frame index is odd
    logic [DW*LANES-1:0] data_q, data_d;
    logic                vld_q, busy_q, done_q;

    logic                launch;           // burst starts on this edge
    logic                emit;             // a frame is registered on this edge

    // Next-state / next-frame parameters. All *_d values describe the frame
    // that will be on the bus after this edge, so the lane mux below works
    // from them directly and every output stays a plain flop.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        len_d   = len_q;
        fcnt_d  = fcnt_q;
        base_d  = base_q;
        odd_d   = odd_q;
        launch  = 1'b0;
        emit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && bus.rf_self_mode) begin
                    launch  = 1'b1;
                    emit    = 1'b1;
                    state_d = ST_RUN;
                    mode_d  = bus.rf_pat_mode;
                    seed_d  = bus.rf_pat_seed;
                    len_d   = bus.rf_burst_len;
                    fcnt_d  = 16'd0;
                    base_d  = bus.rf_pat_seed;
                    odd_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!bus.rf_self_mode) begin
                    // Abort: straight back to idle, no done pulse.
                    state_d = ST_IDLE;
                end else if (len_q != 16'd0 && fcnt_q == len_q - 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    emit   = 1'b1;
                    fcnt_d = fcnt_q + 16'd1;   // wraps freely in continuous mode
                    base_d = base_q + DW'(LANES);
                    odd_d  = ~odd_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ADC_PKT_GEN_PRBS_EN
    // prbs_q holds the LFSR state of the NEXT frame to emit, so a single
    // unrolled chain serves both the lane values and the per-frame advance.
    logic [8:0] prbs_q, prbs_d;
    logic [8:0] chain [0:LANES];

    assign chain[0] = launch ? ((bus.rf_pat_seed == '0) ? 9'h1FF : 9'(bus.rf_pat_seed))
                             : prbs_q;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lfsr
        assign chain[gi+1] = {chain[gi][7:0], chain[gi][8] ^ chain[gi][4]};
    end

    always_comb begin
        prbs_d = prbs_q;
        if (emit) begin
            prbs_d = chain[LANES];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prbs_q <= 9'd0;
        end else begin
            prbs_q <= prbs_d;
        end
    end
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [DW-1:0] lane_val;
        always_comb begin
            case (mode_d)
                2'd1:    lane_val = seed_d;
                2'd3:    lane_val = odd_d ? ~seed_d : seed_d;
`ifdef ADC_PKT_GEN_PRBS_EN
                2'd2:    lane_val = DW'(chain[gi]);
`endif
                default: lane_val = base_d + DW'(gi);
            endcase
        end
        assign data_d[DW*gi +: DW] = emit ? lane_val : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            seed_q  <= '0;
            len_q   <= 16'd0;
            fcnt_q  <= 16'd0;
            base_q  <= '0;
            odd_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            fcnt_q  <= fcnt_d;
            base_q  <= base_d;
            odd_q   <= odd_d;
            data_q  <= data_d;
            vld_q   <= emit;
            busy_q  <= (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign bus.pkt_gen_data = data_q;
    assign bus.pkt_gen_vld  = vld_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_adc_pkt_gen.sv
// tb_adc_pkt_gen
//   Self-checking bench for adc_pkt_gen: directed pattern checks (ramp wrap,
//   toggle, constant, PRBS seeds), abort, mid-burst reset and a set of
//   random bursts compared against a frame-level reference model.
//   Compile with or without ADC_PKT_GEN_PRBS_EN; the model follows the define.
module tb_adc_pkt_gen;
    localparam int LANES = 96;
    localparam int DW    = 9;
    localparam int W     = LANES * DW;

`ifdef ADC_PKT_GEN_PRBS_EN
    localparam bit PRBS_ON = 1'b1;
`else
    localparam bit PRBS_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    logic [W-1:0] cap [0:15];

    adc_pkt_gen_if #(.LANES(LANES), .DW(DW)) bus_if ();

    adc_pkt_gen #(.LANES(LANES), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] lfsr_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    function automatic logic [W-1:0] lane_of(input logic [W-1:0] f, input int i);
        return W'(f[DW*i +: DW]);
    endfunction

    // Frame k of a burst, computed lane by lane from the pattern definitions.
    // PRBS uses the 511-step period of the maximal-length LFSR to jump to the
    // frame start instead of tracking state across frames.
    function automatic logic [W-1:0] model_frame(input int mode, input int seed, input int k);
        logic [W-1:0] f;
        logic [8:0]   s;
        int           m;
        int           v;
        int           mask;
        f    = '0;
        m    = mode;
        mask = (1 << DW) - 1;
        if (m == 2 && !PRBS_ON) m = 0;
        if (m == 2) begin
            s = (seed == 0) ? 9'h1FF : 9'(seed);
            repeat ((k * LANES) % 511) s = lfsr_step(s);
            for (int i = 0; i < LANES; i++) begin
                f[DW*i +: DW] = DW'(s);
                s = lfsr_step(s);
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                case (m)
                    1:       v = seed;
                    3:       v = (k % 2 == 1) ? (~seed & mask) : seed;
                    default: v = (seed + k * LANES + i) % (1 << DW);
                endcase
                f[DW*i +: DW] = DW'(v);
            end
        end
        return f;
    endfunction

    // One burst: launch, check every frame, then the done/abort cycle and the
    // following idle cycle. Register fields are scrambled during the burst and
    // stray start pulses are issued; neither may disturb the frames.
    task automatic run_burst(input int mode, input int seed, input int len, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        $display("burst mode=%0d seed=%03h len=%0d abort_at=%0d", mode, seed, len, abort_at);
        bus_if.rf_self_mode = 1'b1;
        bus_if.rf_pat_mode  = 2'(mode);
        bus_if.rf_pat_seed  = DW'(seed);
        bus_if.rf_burst_len = 16'(len);
        bus_if.start        = 1'b1;
        @(posedge clk); #1;
        bus_if.start        = 1'b0;
        bus_if.rf_pat_mode  = 2'($urandom);
        bus_if.rf_pat_seed  = DW'($urandom);
        bus_if.rf_burst_len = 16'($urandom);
        for (int k = 0; k < 4096; k++) begin
            if (k < 16) cap[k] = bus_if.pkt_gen_data;
            check_eq("vld", W'(bus_if.pkt_gen_vld), W'(1));
            check_eq("busy", W'(bus_if.busy), W'(1));
            check_eq("done_early", W'(bus_if.done), W'(0));
            check_eq("frame", bus_if.pkt_gen_data, model_frame(mode, seed, k));
            if (len != 0 && k == len - 1) break;
            if (k == abort_at) begin
                bus_if.rf_self_mode = 1'b0;
                bus_if.start        = 1'b1;   // start coinciding with abort
                aborted             = 1'b1;
                break;
            end
            bus_if.start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check_eq("end_vld", W'(bus_if.pkt_gen_vld), W'(0));
        check_eq("end_busy", W'(bus_if.busy), W'(0));
        check_eq("end_data", bus_if.pkt_gen_data, W'(0));
        check_eq("end_done", W'(bus_if.done), aborted ? W'(0) : W'(1));
        @(posedge clk); #1;
        check_eq("idle_done", W'(bus_if.done), W'(0));
        check_eq("idle_busy", W'(bus_if.busy), W'(0));
        check_eq("idle_vld", W'(bus_if.pkt_gen_vld), W'(0));
    endtask

    initial begin
        int seed_r;
        n_assert = 0;
        n_fail   = 0;
        rst                 = 1'b1;
        bus_if.rf_self_mode = 1'b0;
        bus_if.rf_pat_mode  = 2'd0;
        bus_if.rf_pat_seed  = '0;
        bus_if.rf_burst_len = 16'd0;
        bus_if.start        = 1'b0;

        #2;
        check_eq("rst_data", bus_if.pkt_gen_data, W'(0));
        check_eq("rst_vld", W'(bus_if.pkt_gen_vld), W'(0));
        check_eq("rst_busy", W'(bus_if.busy), W'(0));
        check_eq("rst_done", W'(bus_if.done), W'(0));
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Ramp wrap-around
        run_burst(0, 9'h1F0, 2, -1);
        check_eq("ramp_f0_l0", lane_of(cap[0], 0), W'(9'h1F0));
        check_eq("ramp_f0_l15", lane_of(cap[0], 15), W'(9'h1FF));
        check_eq("ramp_f0_l16", lane_of(cap[0], 16), W'(9'h000));
        check_eq("ramp_f0_l95", lane_of(cap[0], 95), W'(9'h04F));
        check_eq("ramp_f1_l0", lane_of(cap[1], 0), W'(9'h050));

        // Toggle then constant
        run_burst(3, 9'h0A5, 3, -1);
        check_eq("tog_f0", lane_of(cap[0], 40), W'(9'h0A5));
        check_eq("tog_f1", lane_of(cap[1], 40), W'(9'h15A));
        check_eq("tog_f2", lane_of(cap[2], 95), W'(9'h0A5));
        run_burst(1, 9'h0A5, 3, -1);
        check_eq("const_f1", lane_of(cap[1], 7), W'(9'h0A5));
        check_eq("const_f2", lane_of(cap[2], 95), W'(9'h0A5));

        // PRBS seeds (ramp values when the LFSR is not built)
        run_burst(2, 9'h001, 1, -1);
        check_eq("prbs_l0", lane_of(cap[0], 0), W'(9'h001));
        check_eq("prbs_l1", lane_of(cap[0], 1), W'(9'h002));
        check_eq("prbs_l8", lane_of(cap[0], 8), PRBS_ON ? W'(9'h100) : W'(9'h009));
        check_eq("prbs_l9", lane_of(cap[0], 9), PRBS_ON ? W'(9'h001) : W'(9'h00A));
        run_burst(2, 9'h000, 1, -1);
        check_eq("prbs_seed0", lane_of(cap[0], 0), PRBS_ON ? W'(9'h1FF) : W'(9'h000));

        // Abort a continuous burst at frame 10, then a start with self mode off
        run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)), 0, 10);
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check_eq("nomode_busy", W'(bus_if.busy), W'(0));
        check_eq("nomode_vld", W'(bus_if.pkt_gen_vld), W'(0));
        @(posedge clk); #1;
        check_eq("nomode_busy2", W'(bus_if.busy), W'(0));

        // Random bursts
        for (int b = 0; b < 20; b++) begin
            run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 511)),
                      int'($urandom_range(1, 6)), -1);
        end
        // Longer PRBS burst to cross several frame boundaries
        run_burst(2, int'($urandom_range(0, 511)), 8, -1);

        // Asynchronous reset in the middle of a continuous burst
        seed_r = int'($urandom_range(0, 511));
        $display("burst mode=0 seed=%03h len=0 reset mid-burst", seed_r);
        bus_if.rf_self_mode = 1'b1;
        bus_if.rf_pat_mode  = 2'd0;
        bus_if.rf_pat_seed  = DW'(seed_r);
        bus_if.rf_burst_len = 16'd0;
        bus_if.start        = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check_eq("pre_rst_busy", W'(bus_if.busy), W'(1));
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_data", bus_if.pkt_gen_data, W'(0));
        check_eq("arst_vld", W'(bus_if.pkt_gen_vld), W'(0));
        check_eq("arst_busy", W'(bus_if.busy), W'(0));
        check_eq("arst_done", W'(bus_if.done), W'(0));
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_idle", W'(bus_if.busy), W'(0));
        run_burst(0, seed_r, 2, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
